// File: rtl/bsg_noc_pkg.sv
// Shared mesh/ruche direction constants; X-ruche lanes are indexed by W and E.
package bsg_noc_pkg;

    typedef enum logic [2:0] {
        P = 3'd0,
        W = 3'd1,
        E = 3'd2,
        N = 3'd3,
        S = 3'd4
    } Dirs;

endpackage

// File: rtl/bsg_manycore_ruche_lane_fifo.sv
// One buffered ruche lane: circular FIFO, registered outputs, no empty bypass.
module bsg_manycore_ruche_lane_fifo #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               live_q;
    logic               enq, deq;

    // live_q keeps ready low through reset and for the first edge after release
    assign ready_o = live_q & (cnt_q < CNT_W'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (enq) wr_d = wr_q + PTR_W'(1);
        if (deq) rd_d = rd_q + PTR_W'(1);
        if (enq && !deq)      cnt_d = cnt_q + CNT_W'(1);
        else if (!enq && deq) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            live_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            live_q <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_ruche_x_feedthrough_buffer.sv
// X-direction ruche feedthrough: W input feeds E output and vice versa, per
// channel either buffered by a lane FIFO or a plain wire, with stall counters.
module bsg_manycore_ruche_x_feedthrough_buffer
    import bsg_noc_pkg::*;
#(
    parameter int                          ruche_factor_X_p  = 3,
    parameter int                          width_p           = 64,
    parameter int                          els_p             = 2,
    parameter logic [ruche_factor_X_p-1:0] buffer_mask_p     = '1,
    parameter int                          stall_cnt_width_p = 16
) (
    input  logic                                                      clk_i,
    input  logic                                                      reset_n_i,
    input  logic [ruche_factor_X_p-1:0][E:W]                          v_i,
    input  logic [ruche_factor_X_p-1:0][E:W][width_p-1:0]             data_i,
    output logic [ruche_factor_X_p-1:0][E:W]                          ready_o,
    output logic [ruche_factor_X_p-1:0][E:W]                          v_o,
    output logic [ruche_factor_X_p-1:0][E:W][width_p-1:0]             data_o,
    input  logic [ruche_factor_X_p-1:0][E:W]                          ready_i,
    input  logic                                                      stall_clear_i,
    output logic [ruche_factor_X_p-1:0][E:W][stall_cnt_width_p-1:0]   stall_cnt_o
);

    for (genvar i = 0; i < ruche_factor_X_p; i++) begin : g_ch
        // d is the output side; DI is the opposite input side feeding it
        for (genvar d = int'(W); d <= int'(E); d++) begin : g_dir
            localparam int DI = (d == int'(W)) ? int'(E) : int'(W);

            if (buffer_mask_p[i]) begin : g_buf
                bsg_manycore_ruche_lane_fifo #(
                    .width_p(width_p),
                    .els_p  (els_p)
                ) fifo (
                    .clk_i    (clk_i),
                    .reset_n_i(reset_n_i),
                    .v_i      (v_i[i][DI]),
                    .data_i   (data_i[i][DI]),
                    .ready_o  (ready_o[i][DI]),
                    .v_o      (v_o[i][d]),
                    .data_o   (data_o[i][d]),
                    .ready_i  (ready_i[i][d])
                );
            end else begin : g_pass
                assign v_o[i][d]     = v_i[i][DI];
                assign data_o[i][d]  = data_i[i][DI];
                assign ready_o[i][DI] = ready_i[i][d];
            end

            logic [stall_cnt_width_p-1:0] cnt_q, cnt_d;

            // Saturating; clear has priority over a same-cycle stall.
            always_comb begin
                cnt_d = cnt_q;
                if (stall_clear_i)
                    cnt_d = '0;
                else if (v_o[i][d] && !ready_i[i][d] && !(&cnt_q))
                    cnt_d = cnt_q + stall_cnt_width_p'(1);
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) cnt_q <= '0;
                else            cnt_q <= cnt_d;
            end

            assign stall_cnt_o[i][d] = cnt_q;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_ruche_x_feedthrough_buffer.sv
// Directed checks on an all-buffered instance (A) and a mixed-mask instance (B),
// followed by a randomized per-lane scoreboard run on A.
module tb_bsg_manycore_ruche_x_feedthrough_buffer;
    import bsg_noc_pkg::*;

    localparam int RF = 3;
    localparam int WD = 16;
    localparam int SW = 4;

    logic clk, rst_n;

    logic [RF-1:0][E:W]         a_v_i, a_ready_o, a_v_o, a_ready_i;
    logic [RF-1:0][E:W][WD-1:0] a_data_i, a_data_o;
    logic [RF-1:0][E:W][SW-1:0] a_cnt;
    logic                       a_clr;

    logic [RF-1:0][E:W]         b_v_i, b_ready_o, b_v_o, b_ready_i;
    logic [RF-1:0][E:W][WD-1:0] b_data_i, b_data_o;
    logic [RF-1:0][E:W][SW-1:0] b_cnt;
    logic                       b_clr;

    int checks = 0;
    int errors = 0;

    bsg_manycore_ruche_x_feedthrough_buffer #(
        .ruche_factor_X_p(RF), .width_p(WD), .els_p(2),
        .buffer_mask_p(3'b111), .stall_cnt_width_p(SW)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(a_v_i), .data_i(a_data_i), .ready_o(a_ready_o),
        .v_o(a_v_o), .data_o(a_data_o), .ready_i(a_ready_i),
        .stall_clear_i(a_clr), .stall_cnt_o(a_cnt)
    );

    bsg_manycore_ruche_x_feedthrough_buffer #(
        .ruche_factor_X_p(RF), .width_p(WD), .els_p(2),
        .buffer_mask_p(3'b101), .stall_cnt_width_p(SW)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready_o),
        .v_o(b_v_o), .data_o(b_data_o), .ready_i(b_ready_i),
        .stall_clear_i(b_clr), .stall_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] seq [6];
    logic [15:0] sbq [6][$];
    logic [15:0] exp_d;
    Dirs         dv;
    int          nxt_in, nxt_out;
    logic        acc;

    initial begin
        rst_n = 1'b0;
        a_v_i = '0; a_data_i = '0; a_ready_i = '0; a_clr = 1'b0;
        b_v_i = '0; b_data_i = '0; b_ready_i = '0; b_clr = 1'b0;
        for (int k = 0; k < 6; k++) seq[k] = 16'(k * 4096);

        // Reset state; pass-through lanes of B stay live in reset
        b_v_i[1][W] = 1'b1; b_data_i[1][W] = 16'h33; b_ready_i[1][E] = 1'b1;
        #3;
        chk("rst_a_v_o", 32'(a_v_o), 32'h0);
        chk("rst_a_ready_o", 32'(a_ready_o), 32'h0);
        chk("rst_a_cnt", 32'(a_cnt), 32'h0);
        chk("rst_b_buf_ready", 32'(b_ready_o[0][W]), 32'h0);
        chk("rst_b_pt_v", 32'(b_v_o[1][E]), 32'h1);
        chk("rst_b_pt_data", 32'(b_data_o[1][E]), 32'h33);
        chk("rst_b_pt_ready", 32'(b_ready_o[1][W]), 32'h1);
        b_v_i = '0; b_ready_i = '0;
        tick(); tick();

        // Release mid-cycle: ready rises only after the next edge
        rst_n = 1'b1;
        #1 chk("rel_ready_low", 32'(a_ready_o), 32'h0);
        tick();
        chk("rel_ready_high", 32'(a_ready_o), 32'h3f);

        // Single flit, one-cycle latency, no bypass
        a_ready_i = '1;
        a_v_i[1][W] = 1'b1; a_data_i[1][W] = 16'hA5;
        #1 chk("lat_no_bypass", 32'(a_v_o[1][E]), 32'h0);
        tick();
        a_v_i[1][W] = 1'b0;
        #1 chk("lat_v", 32'(a_v_o[1][E]), 32'h1);
        chk("lat_data", 32'(a_data_o[1][E]), 32'hA5);
        tick();
        #1 chk("lat_drained", 32'(a_v_o[1][E]), 32'h0);

        // Mixed mask: channel 1 is a wire
        b_ready_i[1][W] = 1'b0;
        b_v_i[1][E] = 1'b1; b_data_i[1][E] = 16'h5A;
        b_v_i[0][W] = 1'b1; b_data_i[0][W] = 16'h3C;
        #1 chk("pt_v", 32'(b_v_o[1][W]), 32'h1);
        chk("pt_data", 32'(b_data_o[1][W]), 32'h5A);
        chk("pt_ready0", 32'(b_ready_o[1][E]), 32'h0);
        chk("pt_buf_no_bypass", 32'(b_v_o[0][E]), 32'h0);
        chk("pt_buf_ready", 32'(b_ready_o[0][W]), 32'h1);
        b_ready_i[1][W] = 1'b1; b_data_i[1][E] = 16'hC3;
        #1 chk("pt_ready1", 32'(b_ready_o[1][E]), 32'h1);
        chk("pt_data2", 32'(b_data_o[1][W]), 32'hC3);
        b_ready_i[0][E] = 1'b1;
        tick();
        b_v_i[0][W] = 1'b0;
        #1 chk("b_buf_v", 32'(b_v_o[0][E]), 32'h1);
        chk("b_buf_data", 32'(b_data_o[0][E]), 32'h3C);

        // Fill with output stalled, then drain in order
        a_ready_i[2][E] = 1'b0;
        a_v_i[2][W] = 1'b1; a_data_i[2][W] = 16'd1;
        #1 chk("fill_rdy0", 32'(a_ready_o[2][W]), 32'h1);
        chk("fill_cnt0", 32'(a_cnt[2][E]), 32'h0);
        tick();
        a_data_i[2][W] = 16'd2;
        #1 chk("fill_rdy1", 32'(a_ready_o[2][W]), 32'h1);
        chk("fill_cnt1", 32'(a_cnt[2][E]), 32'h0);
        tick();
        a_data_i[2][W] = 16'd3;
        #1 chk("fill_full_rdy", 32'(a_ready_o[2][W]), 32'h0);
        chk("fill_cnt2", 32'(a_cnt[2][E]), 32'h1);
        chk("fill_head", 32'(a_data_o[2][E]), 32'h1);
        tick();
        #1 chk("fill_cnt3", 32'(a_cnt[2][E]), 32'h2);
        tick();
        #1 chk("fill_cnt4", 32'(a_cnt[2][E]), 32'h3);
        a_ready_i[2][E] = 1'b1;
        #1 chk("full_rdy_with_ready_i", 32'(a_ready_o[2][W]), 32'h0);
        nxt_in = 3; nxt_out = 1;
        for (int c = 0; c < 12 && nxt_out <= 4; c++) begin
            acc = a_v_i[2][W] & a_ready_o[2][W];
            if (a_v_o[2][E]) begin
                chk("drain_order", 32'(a_data_o[2][E]), 32'(nxt_out));
                nxt_out++;
            end
            tick();
            if (acc) begin
                if (nxt_in == 4) a_v_i[2][W] = 1'b0;
                else begin nxt_in++; a_data_i[2][W] = 16'(nxt_in); end
            end
            #1;
        end
        chk("drain_count", 32'(nxt_out), 32'd5);
        chk("drain_cnt_hold", 32'(a_cnt[2][E]), 32'h3);

        // Stall counter saturation and clear
        a_ready_i[0][E] = 1'b0;
        a_v_i[0][W] = 1'b1; a_data_i[0][W] = 16'h77;
        tick();
        a_v_i[0][W] = 1'b0;
        repeat (20) tick();
        #1 chk("sat_cnt", 32'(a_cnt[0][E]), 32'hf);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        #1 chk("clr_cnt", 32'(a_cnt[0][E]), 32'h0);
        chk("clr_other", 32'(a_cnt[2][E]), 32'h0);
        tick();
        #1 chk("clr_restart", 32'(a_cnt[0][E]), 32'h1);
        a_ready_i[0][E] = 1'b1;
        #1 chk("sat_flit", 32'(a_data_o[0][E]), 32'h77);
        tick();
        #1 chk("sat_drained", 32'(a_v_o[0][E]), 32'h0);

        // Async reset of a full FIFO discards its contents
        a_ready_i[0][E] = 1'b0;
        a_v_i[0][W] = 1'b1; a_data_i[0][W] = 16'h11;
        tick();
        a_data_i[0][W] = 16'h22;
        tick();
        a_v_i[0][W] = 1'b0;
        #1 chk("ar_full", 32'(a_ready_o[0][W]), 32'h0);
        chk("ar_v_before", 32'(a_v_o[0][E]), 32'h1);
        rst_n = 1'b0;
        #1 chk("ar_v_async", 32'(a_v_o), 32'h0);
        chk("ar_ready_async", 32'(a_ready_o), 32'h0);
        chk("ar_cnt_async", 32'(a_cnt), 32'h0);
        chk("ar_b_pt_live", 32'(b_v_o[1][W]), 32'h1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        a_ready_i = '1;
        #1 chk("ar_no_stale", 32'(a_v_o), 32'h0);
        chk("ar_ready_back", 32'(a_ready_o), 32'h3f);
        tick();
        #1 chk("ar_no_stale2", 32'(a_v_o), 32'h0);

        // Random valid/ready on all lanes with a per-output-lane scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < RF; i++) begin
                for (int d = 0; d < 2; d++) begin
                    dv = (d != 0) ? E : W;
                    a_v_i[i][dv]     = ($urandom_range(0, 3) != 0);
                    a_ready_i[i][dv] = ($urandom_range(0, 3) != 0);
                    a_data_i[i][dv]  = seq[i*2+d];
                end
            end
            #1;
            for (int i = 0; i < RF; i++) begin
                for (int d = 0; d < 2; d++) begin
                    dv = (d != 0) ? E : W;
                    if (a_v_o[i][dv] && a_ready_i[i][dv]) begin
                        if (sbq[i*2+d].size() == 0) begin
                            chk("rnd_spurious", 32'(a_data_o[i][dv]), 32'hffff_ffff);
                        end else begin
                            exp_d = sbq[i*2+d].pop_front();
                            chk("rnd_data", 32'(a_data_o[i][dv]), 32'(exp_d));
                        end
                    end
                    if (a_v_i[i][dv] && a_ready_o[i][dv]) begin
                        sbq[i*2+(1-d)].push_back(seq[i*2+d]);
                        seq[i*2+d] = seq[i*2+d] + 16'd1;
                    end
                end
            end
            tick();
        end
        a_v_i = '0;
        a_ready_i = '1;
        repeat (4) begin
            #1;
            for (int i = 0; i < RF; i++) begin
                for (int d = 0; d < 2; d++) begin
                    dv = (d != 0) ? E : W;
                    if (a_v_o[i][dv]) begin
                        if (sbq[i*2+d].size() == 0) begin
                            chk("rnd_spurious_drain", 32'(a_data_o[i][dv]), 32'hffff_ffff);
                        end else begin
                            exp_d = sbq[i*2+d].pop_front();
                            chk("rnd_drain_data", 32'(a_data_o[i][dv]), 32'(exp_d));
                        end
                    end
                end
            end
            tick();
        end
        for (int k = 0; k < 6; k++) chk("rnd_lost", 32'(sbq[k].size()), 32'h0);
        #1 chk("rnd_idle", 32'(a_v_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
